// File: rtl/or16_arbiter_pkg.sv
// Shared types and constants for the two-requester or16 arbiter.
package or16_arbiter_pkg;

  localparam int OP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } opnd_t;

endpackage

// File: rtl/or16.sv
// 16-bit bitwise OR gate shared by the arbiter.
module or16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  assign y = a | b;
endmodule

// File: rtl/or16_arbiter.sv
// Round-robin front end sharing one or16 between two valid/ready requesters;
// one transaction in flight, result held in a register until consumed.
module or16_arbiter
  import or16_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp0_out,
  output logic [WIDTH-1:0] rsp1_out,
  output logic             busy,
  output logic [15:0]      done_count
);

  if (WIDTH != OP_W) begin : g_width_chk
    $error("or16_arbiter: WIDTH must be 16");
  end

  state_t           state, state_nxt;
  logic             last, owner, gnt, gnt_vld, acc, rsp_rdy_own;
  opnd_t            opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, or_y;

  // Contested grant goes to whoever did not complete last.
  assign gnt_vld     = req0_valid | req1_valid;
  assign gnt         = (req0_valid & req1_valid) ? ~last : req1_valid;
  assign acc         = (state == ST_IDLE) & gnt_vld;
  assign opnd_d      = (gnt == REQ1) ? opnd_t'{req1_a, req1_b} : opnd_t'{req0_a, req0_b};
  assign rsp_rdy_own = (owner == REQ1) ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (acc) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_rdy_own) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy       = 1'b0;
        req0_ready = gnt_vld & (gnt == REQ0);
        req1_ready = gnt_vld & (gnt == REQ1);
      end
      ST_RESP: begin
        rsp0_valid = (owner == REQ0);
        rsp1_valid = (owner == REQ1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q     <= '0;
      res_q      <= '0;
      owner      <= REQ0;
      last       <= REQ1;
      done_count <= '0;
    end else begin
      if (acc) begin
        opnd_q <= opnd_d;
        owner  <= gnt;
      end
      if (state == ST_EXEC) res_q <= or_y;
      if (state == ST_RESP && rsp_rdy_own) begin
        last       <= owner;
        done_count <= done_count + 16'd1;
      end
    end
  end

  or16 u_or16 (
    .a (opnd_q.a),
    .b (opnd_q.b),
    .y (or_y)
  );

  assign rsp0_out = res_q;
  assign rsp1_out = res_q;

endmodule

// File: tb/tb_or16_arbiter.sv
// Directed and randomized bench for or16_arbiter against a transaction-level model.
module tb_or16_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp0_out, rsp1_out, done_count;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  // model state: who completed last, and completions so far
  int m_last = 1;
  int m_cnt  = 0;

  or16_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_out(rsp0_out), .rsp1_out(rsp1_out),
    .busy(busy), .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; hold = cycles of response back-pressure.
  task automatic txn(input bit v0, input bit v1, input logic [15:0] a0, input logic [15:0] b0,
                     input logic [15:0] a1, input logic [15:0] b1, input int hold);
    int g;
    logic [15:0] e, out;
    g = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
    e = (g == 1) ? (a1 | b1) : (a0 | b0);
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 16'(0));
    chk("gnt0", req0_ready, 16'(g == 0));
    chk("gnt1", req1_ready, 16'(g == 1));
    @(negedge clk);
    if (g == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
    req0_a = 16'($urandom); req0_b = 16'($urandom);
    req1_a = 16'($urandom); req1_b = 16'($urandom);
    #1;
    chk("exec_busy", busy, 16'(1));
    chk("exec_rsp0", rsp0_valid, 16'(0));
    chk("exec_rsp1", rsp1_valid, 16'(0));
    chk("exec_rdy", {req0_ready, req1_ready}, 16'(0));
    @(negedge clk);
    #1;
    out = (g == 1) ? rsp1_out : rsp0_out;
    chk("rsp_v0", rsp0_valid, 16'(g == 0));
    chk("rsp_v1", rsp1_valid, 16'(g == 1));
    chk("rsp_out", out, e);
    chk("rsp_rdy", {req0_ready, req1_ready}, 16'(0));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      if (g == 1) rsp0_ready = 1'($urandom_range(0, 1));
      else        rsp1_ready = 1'($urandom_range(0, 1));
      #1;
      out = (g == 1) ? rsp1_out : rsp0_out;
      chk("bp_valid", {rsp1_valid, rsp0_valid}, (g == 1) ? 16'd2 : 16'd1);
      chk("bp_out", out, e);
      chk("bp_rdy", {req0_ready, req1_ready}, 16'(0));
      chk("bp_cnt", done_count, 16'(m_cnt));
    end
    @(negedge clk);
    if (g == 1) begin rsp1_ready = 1'b1; rsp0_ready = 1'($urandom_range(0, 1)); end
    else        begin rsp0_ready = 1'b1; rsp1_ready = 1'($urandom_range(0, 1)); end
    @(posedge clk);
    m_last = g;
    m_cnt  = (m_cnt + 1) % 65536;
    #1;
    chk("done_busy", busy, 16'(0));
    chk("done_rspv", {rsp0_valid, rsp1_valid}, 16'(0));
    chk("done_cnt", done_count, 16'(m_cnt));
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_last = 1; m_cnt = 0;
  endtask

  // stage 1: reset during EXEC, stage 2: reset during RESP
  task automatic mid_reset(input int stage);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 16'($urandom); req0_b = 16'($urandom);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    if (stage == 2) @(negedge clk);
    #1;
    chk("mr_busy_pre", busy, 16'(1));
    chk("mr_rspv_pre", rsp0_valid, 16'(stage == 2));
    #1 rst_n = 1'b0;
    #1;
    m_last = 1; m_cnt = 0;
    chk("mr_rspv", {rsp0_valid, rsp1_valid}, 16'(0));
    chk("mr_busy", busy, 16'(0));
    chk("mr_cnt", done_count, 16'(m_cnt));
    chk("mr_out", rsp0_out, 16'(0));
    @(negedge clk);
    rst_n = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("mr_norsp", {rsp0_valid, rsp1_valid, busy}, 16'(0));
      chk("mr_cnt_after", done_count, 16'(m_cnt));
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 16'(0));
    chk("rst_rspv", {rsp0_valid, rsp1_valid}, 16'(0));
    chk("rst_cnt", done_count, 16'(0));
    req1_valid = 1'b1;
    #1;
    chk("rst_rdy1", req1_ready, 16'(1));
    chk("rst_rdy0", req0_ready, 16'(0));
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single op
    txn(1, 0, 16'h00F0, 16'h0F01, 16'h0, 16'h0, 0);
    chk("single_cnt", done_count, 16'd1);

    // contention from reset, alternating grants
    pulse_reset();
    for (int r = 0; r < 4; r++)
      txn(1, 1, 16'h0001, 16'h0002, 16'h8000, 16'h4000, 0);

    // back-pressure on requester 1, then req0 accepted right after
    txn(0, 1, 16'h0, 16'h0, 16'h1234, 16'h0F0F, 5);
    txn(1, 0, 16'hA000, 16'h0005, 16'h0, 16'h0, 0);

    mid_reset(1);
    mid_reset(2);

    // single-bit operand sweep, alternating requesters
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        logic [15:0] a, b;
        bit k;
        a = 16'(1 << i);
        b = 16'(1 << j);
        k = bit'((i * 16 + j) % 2);
        txn(!k, k, a, b, a, b, 0);
      end

    // random traffic
    for (int n = 0; n < 150; n++) begin
      int vv;
      vv = $urandom_range(1, 3);
      txn(vv[0], vv[1], 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
          $urandom_range(0, 3));
    end

    // counter wrap
    @(negedge clk);
    force dut.done_count = 16'hFFFE;
    #1 release dut.done_count;
    m_cnt = 16'hFFFE;
    #1 chk("wrap_preload", done_count, 16'hFFFE);
    txn(1, 0, 16'h0101, 16'h1010, 16'h0, 16'h0, 0);
    chk("wrap_ffff", done_count, 16'hFFFF);
    txn(0, 1, 16'h0, 16'h0, 16'h00FF, 16'hFF00, 1);
    chk("wrap_zero", done_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
